// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction/function codes,
// status codes, register sentinel, condition-code layout and the branch test.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;
  localparam logic [3:0] A_MUL = 4'h4;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

  function automatic logic eval_cond(input logic [3:0] ifun, input logic [2:0] flags);
    logic zf, sf, of, res;
    zf = flags[CC_ZF];
    sf = flags[CC_SF];
    of = flags[CC_OF];
    case (ifun)
      4'd0:    res = 1'b1;
      4'd1:    res = (sf ^ of) | zf;
      4'd2:    res = sf ^ of;
      4'd3:    res = zf;
      4'd4:    res = ~zf;
      4'd5:    res = ~(sf ^ of);
      4'd6:    res = ~(sf ^ of) & ~zf;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// Radix-2 shift-add multiplier. The start edge already folds in bit 0, so the
// remaining WIDTH-1 bits take one step each; done flags the final step.
module exec_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, mcand, mplier;

  always_ff @(posedge clk) begin
    if (clear) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      acc    <= b[0] ? a : '0;
      mcand  <= a << 1;
      mplier <= b >> 1;
      count  <= CW'(WIDTH - 2);
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (count != '0) count <= count - CW'(1);
    end
  end

  assign done    = (count == '0);
  assign product = acc;

endmodule

// File: rtl/execute_pipe.sv
// Y86-64 execute stage with condition codes, cmov/jump evaluation, optional
// iterative mulq and the E->M pipeline register with stall/bubble control.
module execute_pipe
  import y86_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic             m_exc,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic             e_busy,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_cnd,
  output logic [2:0]       cc,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  mul_state_t       state, state_n;
  logic             mul_start, mul_step, mul_done;
  logic [WIDTH-1:0] mul_product, add_res, sub_res, alu_res;
  logic             op_of, is_mul, bad_ifun, cc_write;

  exec_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .clear   (rst),
    .start   (mul_start),
    .step    (mul_step),
    .a       (E_valA),
    .b       (E_valB),
    .done    (mul_done),
    .product (mul_product)
  );

  assign add_res = E_valB + E_valA;
  assign sub_res = E_valB - E_valA;

  always_comb begin
    alu_res = '0;
    op_of   = 1'b0;
    case (E_icode)
      I_OPQ: begin
        case (E_ifun)
          A_ADD: begin
            alu_res = add_res;
            op_of   = (E_valA[WIDTH-1] == E_valB[WIDTH-1]) && (add_res[WIDTH-1] != E_valA[WIDTH-1]);
          end
          A_SUB: begin
            alu_res = sub_res;
            op_of   = (E_valA[WIDTH-1] != E_valB[WIDTH-1]) && (sub_res[WIDTH-1] != E_valB[WIDTH-1]);
          end
          A_AND:   alu_res = E_valB & E_valA;
          A_XOR:   alu_res = E_valB ^ E_valA;
          A_MUL:   alu_res = (MUL_EN != 0) ? mul_product : '0;
          default: alu_res = '0;
        endcase
      end
      I_IRMOVQ:          alu_res = E_valC;
      I_RRMOVQ:          alu_res = E_valA;
      I_RMMOVQ, I_MRMOVQ: alu_res = E_valB + E_valC;
      I_CALL, I_PUSHQ:   alu_res = E_valB - WIDTH'(8);
      I_RET, I_POPQ:     alu_res = E_valB + WIDTH'(8);
      default:           alu_res = '0;
    endcase
  end

  assign e_valE   = alu_res;
  assign bad_ifun = ((E_icode == I_OPQ) && ((E_ifun > A_MUL) || ((E_ifun == A_MUL) && (MUL_EN == 0)))) ||
                    (((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) && (E_ifun > 4'd6));
  assign is_mul   = (MUL_EN != 0) && (E_icode == I_OPQ) && (E_ifun == A_MUL) && (E_stat == S_AOK);

  // The start cycle already counts as busy so the hazard unit freezes F/D/E at once.
  always_comb begin
    state_n   = state;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    e_busy    = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (is_mul && !M_stall) begin
          mul_start = 1'b1;
          e_busy    = 1'b1;
          state_n   = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        mul_step = 1'b1;
        e_busy   = 1'b1;
        if (mul_done) state_n = MUL_DONE;
      end
      MUL_DONE: begin
        if (!M_stall) state_n = MUL_IDLE;
      end
      default: state_n = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MUL_IDLE;
    else     state <= state_n;
  end

  assign e_cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) ? eval_cond(E_ifun, cc) : 1'b0;
  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_cnd) ? RNONE : E_dstE;

  assign cc_write = (E_icode == I_OPQ) && !M_stall && !e_busy && (E_stat == S_AOK) && !m_exc && !bad_ifun;

  always_ff @(posedge clk) begin
    if (rst)           cc <= CC_RESET;
    else if (cc_write) cc <= {alu_res == '0, alu_res[WIDTH-1], op_of};
  end

  always_ff @(posedge clk) begin
    if (rst || (!M_stall && (M_bubble || e_busy))) begin
      M_stat  <= S_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (!M_stall) begin
      M_stat  <= bad_ifun ? S_INS : E_stat;
      M_icode <= E_icode;
      M_cnd   <= e_cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: a 64-bit mulq-capable instance and a 16-bit
// instance without mulq, driven by per-feature tasks with inline checks.
module tb_execute_pipe;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        m_exc, M_stall, M_bubble;
  logic        e_busy, e_cnd, M_cnd;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
  logic [2:0]  cc, M_stat;

  logic [2:0]  s_E_stat;
  logic [3:0]  s_E_icode, s_E_ifun;
  logic [15:0] s_E_valA, s_E_valB, s_E_valC;
  logic        s_e_busy, s_e_cnd, s_M_cnd;
  logic [15:0] s_e_valE, s_M_valE, s_M_valA;
  logic [3:0]  s_e_dstE, s_M_icode, s_M_dstE, s_M_dstM;
  logic [2:0]  s_cc, s_M_stat;

  always #5 clk = ~clk;

  execute_pipe #(.WIDTH(64), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_exc(m_exc), .M_stall(M_stall), .M_bubble(M_bubble), .e_busy(e_busy),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .cc(cc), .M_stat(M_stat),
    .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  execute_pipe #(.WIDTH(16), .MUL_EN(0)) dut_s (
    .clk(clk), .rst(rst), .E_stat(s_E_stat), .E_icode(s_E_icode), .E_ifun(s_E_ifun),
    .E_valA(s_E_valA), .E_valB(s_E_valB), .E_valC(s_E_valC), .E_dstE(4'h1), .E_dstM(RNONE),
    .m_exc(1'b0), .M_stall(1'b0), .M_bubble(1'b0), .e_busy(s_e_busy),
    .e_valE(s_e_valE), .e_dstE(s_e_dstE), .e_cnd(s_e_cnd), .cc(s_cc), .M_stat(s_M_stat),
    .M_icode(s_M_icode), .M_cnd(s_M_cnd), .M_valE(s_M_valE), .M_valA(s_M_valA),
    .M_dstE(s_M_dstE), .M_dstM(s_M_dstM)
  );

  task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] va,
                       input logic [63:0] vb, input logic [63:0] vc, input logic [3:0] dst);
    E_stat  = S_AOK;
    E_icode = icode;
    E_ifun  = ifun;
    E_valA  = va;
    E_valB  = vb;
    E_valC  = vc;
    E_dstE  = dst;
    E_dstM  = RNONE;
  endtask

  task automatic test_reset;
    n_checks++; if (cc !== 3'b100) begin n_fail++; $display("[TB] FAIL reset_cc: got %b expected 100", cc); end
    n_checks++; if (M_icode !== I_NOP) begin n_fail++; $display("[TB] FAIL reset_M_icode: got %h expected 1", M_icode); end
    n_checks++; if (M_stat !== S_AOK) begin n_fail++; $display("[TB] FAIL reset_M_stat: got %0d expected 1", M_stat); end
    n_checks++; if (M_dstE !== RNONE) begin n_fail++; $display("[TB] FAIL reset_M_dstE: got %h expected f", M_dstE); end
    n_checks++; if (e_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", e_busy); end
  endtask

  task automatic test_sub_zero;
    set_e(I_OPQ, A_SUB, 64'd5, 64'd5, 64'd0, 4'h3);
    @(posedge clk); #1;
    n_checks++; if (M_valE !== 64'd0) begin n_fail++; $display("[TB] FAIL sub_valE: got %h expected 0", M_valE); end
    n_checks++; if (M_icode !== I_OPQ || M_dstE !== 4'h3) begin n_fail++; $display("[TB] FAIL sub_M_fields: got %h/%h expected 6/3", M_icode, M_dstE); end
    n_checks++; if (cc !== 3'b100) begin n_fail++; $display("[TB] FAIL sub_cc: got %b expected 100", cc); end
    set_e(I_JXX, 4'd1, 64'd0, 64'd0, 64'd0, RNONE); #1;
    n_checks++; if (e_cnd !== 1'b1) begin n_fail++; $display("[TB] FAIL jle_zf: got %b expected 1", e_cnd); end
    E_ifun = 4'd3; #1;
    n_checks++; if (e_cnd !== 1'b1) begin n_fail++; $display("[TB] FAIL je_zf: got %b expected 1", e_cnd); end
    E_ifun = 4'd4; #1;
    n_checks++; if (e_cnd !== 1'b0) begin n_fail++; $display("[TB] FAIL jne_zf: got %b expected 0", e_cnd); end
  endtask

  task automatic test_add_overflow;
    set_e(I_OPQ, A_ADD, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2); #1;
    n_checks++; if (e_valE !== 64'h8000_0000_0000_0000) begin n_fail++; $display("[TB] FAIL add_e_valE: got %h expected 8000000000000000", e_valE); end
    @(posedge clk); #1;
    n_checks++; if (M_valE !== 64'h8000_0000_0000_0000) begin n_fail++; $display("[TB] FAIL add_M_valE: got %h expected 8000000000000000", M_valE); end
    n_checks++; if (cc !== 3'b011) begin n_fail++; $display("[TB] FAIL add_cc: got %b expected 011", cc); end
    set_e(I_JXX, 4'd2, 64'd0, 64'd0, 64'd0, RNONE); #1;
    n_checks++; if (e_cnd !== 1'b0) begin n_fail++; $display("[TB] FAIL jl_of: got %b expected 0", e_cnd); end
    E_ifun = 4'd5; #1;
    n_checks++; if (e_cnd !== 1'b1) begin n_fail++; $display("[TB] FAIL jge_of: got %b expected 1", e_cnd); end
  endtask

  task automatic test_mulq;
    int   busy_cycles;
    logic bubble_ok;
    busy_cycles = 0;
    bubble_ok   = 1'b1;
    set_e(I_OPQ, A_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'd0, 4'h6); #1;
    while (e_busy && busy_cycles < 200) begin
      busy_cycles++;
      @(posedge clk); #1;
      if (M_icode !== I_NOP) bubble_ok = 1'b0;
    end
    n_checks++; if (busy_cycles != 64) begin n_fail++; $display("[TB] FAIL mul_busy_len: got %0d expected 64", busy_cycles); end
    n_checks++; if (bubble_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL mul_bubbles: got %b expected 1", bubble_ok); end
    n_checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("[TB] FAIL mul_e_valE: got %h expected ffffffffffffffeb", e_valE); end
    M_stall = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (M_icode !== I_NOP || e_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mul_stall_hold: got %h/%b expected 1/0", M_icode, e_busy); end
    n_checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFEB || cc !== 3'b011) begin n_fail++; $display("[TB] FAIL mul_stall_done: got %h/%b expected ffffffffffffffeb/011", e_valE, cc); end
    M_stall = 1'b0;
    @(posedge clk); #1;
    set_e(I_NOP, 4'd0, 64'd0, 64'd0, 64'd0, RNONE);
    n_checks++; if (M_valE !== 64'hFFFF_FFFF_FFFF_FFEB || M_icode !== I_OPQ) begin n_fail++; $display("[TB] FAIL mul_M_valE: got %h/%h expected ffffffffffffffeb/6", M_valE, M_icode); end
    n_checks++; if (cc !== 3'b010) begin n_fail++; $display("[TB] FAIL mul_cc: got %b expected 010", cc); end
  endtask

  task automatic test_exc_and_cmov;
    m_exc = 1'b1;
    set_e(I_OPQ, A_AND, 64'h3C, 64'hF0, 64'd0, 4'h2);
    @(posedge clk); #1;
    m_exc = 1'b0;
    n_checks++; if (M_valE !== 64'h30) begin n_fail++; $display("[TB] FAIL exc_M_valE: got %h expected 30", M_valE); end
    n_checks++; if (cc !== 3'b010) begin n_fail++; $display("[TB] FAIL exc_cc_hold: got %b expected 010", cc); end
    set_e(I_OPQ, A_SUB, 64'd5, 64'd5, 64'd0, 4'h2);
    @(posedge clk); #1;
    set_e(I_RRMOVQ, 4'd6, 64'h1234, 64'd0, 64'd0, 4'h5); #1;
    n_checks++; if (e_cnd !== 1'b0 || e_dstE !== RNONE) begin n_fail++; $display("[TB] FAIL cmovg_dstE: got %b/%h expected 0/f", e_cnd, e_dstE); end
    n_checks++; if (e_valE !== 64'h1234) begin n_fail++; $display("[TB] FAIL cmov_valE: got %h expected 1234", e_valE); end
    set_e(I_RRMOVQ, 4'd7, 64'h1, 64'd0, 64'd0, 4'h5);
    @(posedge clk); #1;
    n_checks++; if (M_stat !== S_INS || cc !== 3'b100) begin n_fail++; $display("[TB] FAIL bad_cmov: got %0d/%b expected 4/100", M_stat, cc); end
    set_e(I_IRMOVQ, 4'd0, 64'd0, 64'd0, 64'hABCD, 4'h4);
    M_bubble = 1'b1; #1;
    n_checks++; if (e_valE !== 64'hABCD) begin n_fail++; $display("[TB] FAIL irmovq_valE: got %h expected abcd", e_valE); end
    @(posedge clk); #1;
    M_bubble = 1'b0;
    n_checks++; if (M_icode !== I_NOP || M_dstE !== RNONE) begin n_fail++; $display("[TB] FAIL M_bubble: got %h/%h expected 1/f", M_icode, M_dstE); end
  endtask

  task automatic test_reset_mid_mul;
    int guard;
    set_e(I_OPQ, A_XOR, 64'd1, 64'd0, 64'd0, 4'h2);
    @(posedge clk); #1;
    n_checks++; if (cc !== 3'b000) begin n_fail++; $display("[TB] FAIL xor_cc: got %b expected 000", cc); end
    set_e(I_OPQ, A_MUL, 64'd5, 64'd5, 64'd0, 4'h2);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    set_e(I_NOP, 4'd0, 64'd0, 64'd0, 64'd0, RNONE);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    n_checks++; if (e_busy !== 1'b0 || cc !== 3'b100) begin n_fail++; $display("[TB] FAIL rst_mid_mul: got %b/%b expected 0/100", e_busy, cc); end
    n_checks++; if (M_icode !== I_NOP || M_valE !== 64'd0 || M_dstE !== RNONE) begin n_fail++; $display("[TB] FAIL rst_mid_mul_M: got %h/%h/%h expected 1/0/f", M_icode, M_valE, M_dstE); end
    set_e(I_OPQ, A_MUL, 64'd3, 64'd2, 64'd0, 4'h7); #1;
    guard = 0;
    while (e_busy && guard < 200) begin
      guard++;
      @(posedge clk); #1;
    end
    n_checks++; if (e_valE !== 64'd6 || guard != 64) begin n_fail++; $display("[TB] FAIL mul2x3_e: got %h after %0d expected 6 after 64", e_valE, guard); end
    @(posedge clk); #1;
    set_e(I_NOP, 4'd0, 64'd0, 64'd0, 64'd0, RNONE);
    n_checks++; if (M_valE !== 64'd6 || cc !== 3'b000) begin n_fail++; $display("[TB] FAIL mul2x3_M: got %h/%b expected 6/000", M_valE, cc); end
  endtask

  task automatic test_narrow_nomul;
    s_E_stat = S_AOK; s_E_icode = I_OPQ; s_E_ifun = A_MUL;
    s_E_valA = 16'd2; s_E_valB = 16'd3; s_E_valC = 16'd0; #1;
    n_checks++; if (s_e_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL nomul_busy: got %b expected 0", s_e_busy); end
    @(posedge clk); #1;
    n_checks++; if (s_M_stat !== S_INS || s_cc !== 3'b100) begin n_fail++; $display("[TB] FAIL nomul_ins: got %0d/%b expected 4/100", s_M_stat, s_cc); end
    s_E_icode = I_PUSHQ; s_E_ifun = 4'd0; s_E_valB = 16'h0100; #1;
    n_checks++; if (s_e_valE !== 16'h00F8) begin n_fail++; $display("[TB] FAIL pushq_e_valE: got %h expected 00f8", s_e_valE); end
    @(posedge clk); #1;
    n_checks++; if (s_M_valE !== 16'h00F8 || s_M_stat !== S_AOK) begin n_fail++; $display("[TB] FAIL pushq_M: got %h/%0d expected 00f8/1", s_M_valE, s_M_stat); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    m_exc = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
    set_e(I_NOP, 4'd0, 64'd0, 64'd0, 64'd0, RNONE);
    s_E_stat = S_AOK; s_E_icode = I_NOP; s_E_ifun = 4'd0;
    s_E_valA = '0; s_E_valB = '0; s_E_valC = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; #1;
    test_reset;
    test_sub_zero;
    test_add_overflow;
    test_mulq;
    test_exc_and_cmov;
    test_reset_mid_mul;
    test_narrow_nomul;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
